// File: rtl/wb_pkg.sv
// Shared types and sizing for the register write-back queue.
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DEPTH  = 4;
  localparam int PTR_W     = $clog2(WB_DEPTH);
  localparam bit DEPTH_OK  = (WB_DEPTH >= 2) && ((WB_DEPTH & (WB_DEPTH - 1)) == 0);

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_bypass_cam.sv
// Youngest-match lookup over the occupied queue entries for one read port.
module wb_bypass_cam
  import wb_pkg::*;
(
  input  logic [WB_DEPTH-1:0]             occ,
  input  wb_entry_t [WB_DEPTH-1:0]        ent,
  input  logic [PTR_W-1:0]                head,
  input  logic [WB_ADDR_W-1:0]            addr,
  output logic                            hit,
  output logic [WB_DATA_W-1:0]            data
);
  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (occ[idx] && ent[idx].addr == addr) begin
        hit  = 1'b1;
        data = ent[idx].data;
      end
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// In-order write-back FIFO between WB and the register bank, with read bypass.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int REGISTER_SIZE = WB_DATA_W,
  parameter int ADDRESS_SIZE  = WB_ADDR_W,
  parameter int DEPTH         = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_SIZE-1:0]  mem_addr,
  input  logic [REGISTER_SIZE-1:0] mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDRESS_SIZE-1:0]  alu_addr,
  input  logic [REGISTER_SIZE-1:0] alu_data,
  output logic                     rf_write,
  output logic [ADDRESS_SIZE-1:0]  rf_addr,
  output logic [REGISTER_SIZE-1:0] rf_data,
  input  logic [ADDRESS_SIZE-1:0]  rd_addr1,
  input  logic [ADDRESS_SIZE-1:0]  rd_addr2,
  output logic                     fwd_hit1,
  output logic [REGISTER_SIZE-1:0] fwd_data1,
  output logic                     fwd_hit2,
  output logic [REGISTER_SIZE-1:0] fwd_data2,
  output logic                     empty,
  output logic                     full
);
  if (!DEPTH_OK || DEPTH != WB_DEPTH || REGISTER_SIZE != WB_DATA_W || ADDRESS_SIZE != WB_ADDR_W)
  begin : g_bad_cfg
    $error("writeback_queue: unsupported configuration");
  end

  wb_entry_t [DEPTH-1:0] ent;
  logic [PTR_W-1:0]      head, tail, alu_slot;
  logic [PTR_W:0]        count, free;
  logic [DEPTH-1:0]      occ;
  logic                  mem_acc, alu_acc;

  // Readiness depends only on registered occupancy; ALU keeps a slot spare for MEM.
  assign free      = (PTR_W+1)'(DEPTH) - count;
  assign mem_ready = free >= (PTR_W+1)'(1);
  assign alu_ready = free >= (PTR_W+1)'(2);
  assign mem_acc   = mem_valid & mem_ready;
  assign alu_acc   = alu_valid & alu_ready;
  assign alu_slot  = tail + PTR_W'(mem_acc);

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign rf_write = !empty;
  assign rf_addr  = empty ? '0 : ent[head].addr;
  assign rf_data  = empty ? '0 : ent[head].data;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (mem_acc) ent[tail]     <= '{addr: mem_addr, data: mem_data};
      if (alu_acc) ent[alu_slot] <= '{addr: alu_addr, data: alu_data};
      tail  <= tail + PTR_W'(mem_acc) + PTR_W'(alu_acc);
      head  <= head + PTR_W'(rf_write);
      count <= count + (PTR_W+1)'(mem_acc) + (PTR_W+1)'(alu_acc) - (PTR_W+1)'(rf_write);
    end
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    occ = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PTR_W'(i) - head;
      occ[i] = {1'b0, off} < count;
    end
  end

  wb_bypass_cam u_cam1 (.occ(occ), .ent(ent), .head(head), .addr(rd_addr1),
                        .hit(fwd_hit1), .data(fwd_data1));
  wb_bypass_cam u_cam2 (.occ(occ), .ent(ent), .head(head), .addr(rd_addr2),
                        .hit(fwd_hit2), .data(fwd_data2));
endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed checks of writeback_queue against a queue-based model.
module tb_writeback_queue;
  localparam int D = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_valid = 1'b0, alu_valid = 1'b0;
  logic [4:0]  mem_addr = '0, alu_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [31:0] mem_data = '0, alu_data = '0;
  logic        mem_ready, alu_ready, rf_write, fwd_hit1, fwd_hit2, empty, full;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, fwd_data1, fwd_data2;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  int checks = 0, failures = 0;

  writeback_queue dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0; d = '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a) begin hit = 1'b1; d = q[i].d; break; end
  endtask

  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic [4:0] r1, input logic [4:0] r2);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    rd_addr1 = r1; rd_addr2 = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  // Compare every output against the model a few ns after inputs change.
  task automatic settle_check();
    int n;
    logic h; logic [31:0] d;
    #3;
    n = q.size();
    chk("empty", empty, n == 0);
    chk("full", full, n == D);
    chk("mem_ready", mem_ready, n <= D - 1);
    chk("alu_ready", alu_ready, n <= D - 2);
    chk("rf_write", rf_write, n > 0);
    chk("rf_addr", rf_addr, n > 0 ? q[0].a : 5'd0);
    chk("rf_data", rf_data, n > 0 ? q[0].d : 32'd0);
    lookup(rd_addr1, h, d);
    chk("fwd_hit1", fwd_hit1, h);
    chk("fwd_data1", fwd_data1, d);
    lookup(rd_addr2, h, d);
    chk("fwd_hit2", fwd_hit2, h);
    chk("fwd_data2", fwd_data2, d);
  endtask

  task automatic tick();
    int n;
    n = q.size();
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (n > 0) void'(q.pop_front());
      if (mem_valid && n <= D - 1) q.push_back('{a: mem_addr, d: mem_data});
      if (alu_valid && n <= D - 2) q.push_back('{a: alu_addr, d: alu_data});
    end
    #1;
  endtask

  task automatic step();
    settle_check();
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5'd0, 5'd0);
    step();

    // single ALU write, visible on rf and bypass the next cycle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD, 5'd0, 5'd1);
    step();
    idle(5'd5, 5'd2);
    settle_check();
    chk("dead_rf_addr", rf_addr, 5'd5);
    chk("dead_rf_data", rf_data, 32'hDEAD);
    chk("dead_fwd1", {fwd_hit1, fwd_data1}, {1'b1, 32'hDEAD});
    tick();
    step();

    // MEM older than ALU in the same cycle; youngest wins bypass
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd0, 5'd0);
    step();
    idle(5'd3, 5'd3);
    settle_check();
    chk("pair_first", rf_data, 32'h11);
    chk("pair_fwd_young", fwd_data1, 32'h22);
    tick();
    settle_check();
    chk("pair_second", rf_data, 32'h22);
    tick();
    step();

    // both paths every cycle: ALU backpressure while MEM still fits
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'($urandom_range(0, 7)), $urandom, 1'b1, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    for (int i = 0; i < 6; i++) begin idle(5'd1, 5'd2); step(); end

    // pointer wrap with single enqueues interleaved with drains
    for (int i = 0; i < 3 * D; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(i - 1));
      step();
      idle(5'(i), 5'd0);
      step();
    end
    settle_check();
    chk("wrap_empty", empty, 1'b1);

    // reset mid-burst drops queued entries
    drive(1'b1, 5'd7, 32'hA1, 1'b1, 5'd8, 32'hA2, 5'd7, 5'd8);
    step();
    drive(1'b1, 5'd9, 32'hA3, 1'b1, 5'd10, 32'hA4, 5'd9, 5'd10);
    step();
    idle(5'd9, 5'd10);
    reset = 1'b1;
    drive(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hB2, 5'd9, 5'd10);
    step();
    reset = 1'b0;
    idle(5'd9, 5'd11);
    settle_check();
    chk("rst_rf_write", rf_write, 1'b0);
    chk("rst_empty", empty, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin idle(5'd11, 5'd12); step(); end

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    reset = 1'b0;
    idle(5'd0, 5'd0);
    for (int i = 0; i < 6; i++) step();
    settle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
